// File: rtl/video_sig_gen.sv
// Raster timing generator: walks (hcount, vcount) across the whole frame and emits
// registered sync, active-draw, new-frame and frame-count signals aligned to that position.
module video_sig_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter int unsigned FPS      = 60
) (
  input  logic        i_pixel_clk,
  input  logic        i_rst_n,
  output logic [10:0] o_hcount,
  output logic [9:0]  o_vcount,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_ad,
  output logic        o_nf,
  output logic [5:0]  o_fc
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast   = 11'(H_TOTAL - 1);
  localparam logic [10:0] HActive = 11'(H_ACTIVE);
  localparam logic [10:0] HsFirst = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HsLast  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VActive = 10'(V_ACTIVE);
  localparam logic [9:0]  VsFirst = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VsLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [5:0]  FcLast  = 6'(FPS - 1);

  logic        running_q;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        ad_q, ad_d;
  logic        nf_q, nf_d;
  logic [5:0]  fc_q, fc_d;

  // Flags are computed from the next position so they land in the same cycle as it.
  always_comb begin
    hcount_d = '0;
    vcount_d = '0;
    if (running_q) begin
      if (hcount_q == HLast) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VLast) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
      end
    end

    ad_d = (hcount_d < HActive) && (vcount_d < VActive);
    hs_d = (hcount_d >= HsFirst) && (hcount_d <= HsLast);
    vs_d = (vcount_d >= VsFirst) && (vcount_d <= VsLast);
    nf_d = (hcount_d == HActive) && (vcount_d == VActive);

    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FcLast) ? '0 : fc_q + 6'd1;
    end
  end

  always_ff @(posedge i_pixel_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      running_q <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      ad_q      <= 1'b0;
      nf_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      running_q <= 1'b1;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      ad_q      <= ad_d;
      nf_q      <= nf_d;
      fc_q      <= fc_d;
    end
  end

  assign o_hcount = hcount_q;
  assign o_vcount = vcount_q;
  assign o_hs     = hs_q;
  assign o_vs     = vs_q;
  assign o_ad     = ad_q;
  assign o_nf     = nf_q;
  assign o_fc     = fc_q;

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench: default 720p mode for start-up and line timing, a tiny mode
// (14x7 total, FPS=3) for frame-level timing, frame-count wrap and mid-frame reset.
module tb_video_sig_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic sb_a, sb_b;

  logic [10:0] hc_a, hc_b;
  logic [9:0]  vc_a, vc_b;
  logic        hs_a, hs_b, vs_a, vs_b, ad_a, ad_b, nf_a, nf_b;
  logic [5:0]  fc_a, fc_b;

  int n_checks = 0;
  int n_errors = 0;

  video_sig_gen dut_a (
    .i_pixel_clk(clk),
    .i_rst_n    (rst_a),
    .o_hcount   (hc_a),
    .o_vcount   (vc_a),
    .o_hs       (hs_a),
    .o_vs       (vs_a),
    .o_ad       (ad_a),
    .o_nf       (nf_a),
    .o_fc       (fc_a)
  );

  video_sig_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FPS(3)
  ) dut_b (
    .i_pixel_clk(clk),
    .i_rst_n    (rst_b),
    .o_hcount   (hc_b),
    .o_vcount   (vc_b),
    .o_hs       (hs_b),
    .o_vs       (vs_b),
    .o_ad       (ad_b),
    .o_nf       (nf_b),
    .o_fc       (fc_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Per-cycle alignment of flags against the same-cycle position.
  always @(negedge clk) begin
    #2;
    if (sb_a) begin
      check("sb_a_ad", int'(ad_a), int'(hc_a < 11'd1280 && vc_a < 10'd720));
      check("sb_a_hs", int'(hs_a), int'(hc_a >= 11'd1390 && hc_a <= 11'd1429));
      check("sb_a_vs", int'(vs_a), int'(vc_a >= 10'd725 && vc_a <= 10'd729));
      check("sb_a_nf", int'(nf_a), int'(hc_a == 11'd1280 && vc_a == 10'd720));
    end
    if (sb_b) begin
      check("sb_b_ad", int'(ad_b), int'(hc_b < 11'd8 && vc_b < 10'd4));
      check("sb_b_hs", int'(hs_b), int'(hc_b >= 11'd10 && hc_b <= 11'd11));
      check("sb_b_vs", int'(vs_b), int'(vc_b == 10'd5));
      check("sb_b_nf", int'(nf_b), int'(hc_b == 11'd8 && vc_b == 10'd4));
      check("sb_b_range", int'(hc_b < 11'd14 && vc_b < 10'd7), 1);
    end
  end

  initial begin
    int ad_fall, hs_rise, hs_fall, wrapped, found;
    logic pad, phs;
    logic [10:0] phc;
    int nk, nf_hi, vs_rise_vc, vs_fall_vc, vs_len, wrap_from;
    int nf_cyc[4];
    int nf_fc[4];
    logic pnf, pvs;
    logic [9:0] pvc;

    rst_a = 1'b0;
    rst_b = 1'b0;
    sb_a  = 1'b0;
    sb_b  = 1'b0;

    // Reset hold
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0 || i == 9) begin
        check("rst_hold_a", int'({hc_a, vc_a, hs_a, vs_a, ad_a, nf_a, fc_a}), 0);
        check("rst_hold_b", int'({hc_b, vc_b, hs_b, vs_b, ad_b, nf_b, fc_b}), 0);
      end
    end
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Start-up edge
    @(negedge clk);
    check("start_hc", int'(hc_a), 0);
    check("start_vc", int'(vc_a), 0);
    check("start_ad", int'(ad_a), 1);
    check("start_nf", int'(nf_a), 0);
    check("start_fc", int'(fc_a), 0);
    check("start_b_ad", int'(ad_b), 1);
    sb_a = 1'b1;
    sb_b = 1'b1;
    @(negedge clk);
    check("edge2_hc", int'(hc_a), 1);

    // Horizontal boundaries on line 0
    ad_fall = -1; hs_rise = -1; hs_fall = -1; wrapped = 0;
    pad = ad_a; phs = hs_a; phc = hc_a;
    for (int i = 0; i < 1700 && !wrapped; i++) begin
      @(negedge clk);
      if (pad && !ad_a && ad_fall < 0) ad_fall = int'(hc_a);
      if (!phs && hs_a && hs_rise < 0) hs_rise = int'(hc_a);
      if (phs && !hs_a && hs_fall < 0) hs_fall = int'(hc_a);
      if (phc == 11'd1649) begin
        wrapped = 1;
        check("hwrap_hc", int'(hc_a), 0);
        check("hwrap_vc", int'(vc_a), 1);
      end
      pad = ad_a; phs = hs_a; phc = hc_a;
    end
    check("ad_fall_at", ad_fall, 1280);
    check("hs_rise_at", hs_rise, 1390);
    check("hs_fall_at", hs_fall, 1430);
    check("hwrap_seen", wrapped, 1);

    // Async reset mid-line on the default instance
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (hc_a == 11'd700) found = 1;
    end
    check("a_reach_700", found, 1);
    sb_a  = 1'b0;
    rst_a = 1'b0;
    #1;
    check("a_async_rst", int'({hc_a, vc_a, hs_a, vs_a, ad_a, nf_a, fc_a}), 0);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_restart_hc", int'(hc_a), 0);
    check("a_restart_vc", int'(vc_a), 0);
    check("a_restart_ad", int'(ad_a), 1);
    check("a_restart_fc", int'(fc_a), 0);
    sb_a = 1'b1;

    // Async reset mid-frame on the small instance
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (hc_b == 11'd5 && vc_b == 10'd2) found = 1;
    end
    check("b_reach_pos", found, 1);
    sb_b  = 1'b0;
    rst_b = 1'b0;
    #1;
    check("b_async_rst", int'({hc_b, vc_b, hs_b, vs_b, ad_b, nf_b, fc_b}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check("b_restart_pos", int'({hc_b, vc_b}), 0);
    check("b_restart_ad", int'(ad_b), 1);
    check("b_restart_fc", int'(fc_b), 0);
    check("b_restart_nf", int'(nf_b), 0);
    sb_b = 1'b1;

    // Frame-level timing: cycle k after the first active pixel is position k of the frame
    nk = 0; nf_hi = 0; vs_rise_vc = -1; vs_fall_vc = -1; vs_len = 0; wrap_from = -1;
    for (int k = 0; k < 4; k++) begin
      nf_cyc[k] = -1;
      nf_fc[k]  = -1;
    end
    pnf = nf_b; pvs = vs_b; pvc = vc_b;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      if (nf_b && !pnf) begin
        if (nk < 4) begin
          nf_cyc[nk] = cyc;
          nf_fc[nk]  = int'(fc_b);
        end
        nk++;
      end
      if (nf_b) nf_hi++;
      if (vs_b && !pvs && vs_rise_vc < 0) vs_rise_vc = int'(vc_b);
      if (!vs_b && pvs && vs_fall_vc < 0) vs_fall_vc = int'(vc_b);
      if (vs_b && vs_fall_vc < 0) vs_len++;
      if (vc_b == 10'd0 && pvc != 10'd0 && wrap_from < 0) wrap_from = int'(pvc);
      pnf = nf_b; pvs = vs_b; pvc = vc_b;
    end
    check("b_first_nf_cyc", nf_cyc[0], 64);
    check("b_fc_nf0", nf_fc[0], 1);
    check("b_fc_nf1", nf_fc[1], 2);
    check("b_fc_nf2", nf_fc[2], 0);
    check("b_fc_nf3", nf_fc[3], 1);
    for (int k = 1; k < 4; k++) begin
      check("b_nf_spacing", nf_cyc[k] - nf_cyc[k-1], 98);
    end
    check("b_nf_high_cycles", nf_hi, 5);
    check("b_vs_rise_vc", vs_rise_vc, 5);
    check("b_vs_fall_vc", vs_fall_vc, 6);
    check("b_vs_len", vs_len, 14);
    check("b_vwrap_from", wrap_from, 6);

    sb_a = 1'b0;
    sb_b = 1'b0;
    @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
